// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and helpers for the 16-requester round-robin
// arbiter in front of the 16:1 single-bit mux.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned SEL_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_16cross1.sv
// Plain 16:1 single-bit mux shared by the arbitrated requesters.
module mux_16cross1
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] d,
  input  logic [SEL_W-1:0]   s,
  output logic               y
);

  assign y = d[s];

endmodule

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request at or after ptr (mod 16).
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;

  // Doubling the vector turns the rotate into a plain right shift.
  assign w_dbl = {req, req};
  assign w_rot = NUM_REQ'(w_dbl >> ptr);

  always_comb begin
    w_off = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_rot[NUM_REQ-1-i]) begin
        w_off = SEL_W'(NUM_REQ-1-i);
      end
    end
  end

  assign found = |w_rot;
  assign idx   = ptr + w_off;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter with bounded bursts that owns the select of a 16:1 mux
// and presents the chosen data bit with a valid flag downstream.
module mux16_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               y,
  output logic               burst_end
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic             ONE_SHOT = (MAX_HOLD == 1);

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'(1) << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_param
    $error("mux16_rr_arbiter: MAX_HOLD must be 1..255 and fit in CNT_W bits");
  end

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_valid;
  logic               r_burst_end;

  logic               w_hold_req;
  logic               w_at_max;
  logic               w_end;
  logic [SEL_W-1:0]   w_ptr_after;
  logic [SEL_W-1:0]   w_arb_ptr;
  logic               w_found;
  logic [SEL_W-1:0]   w_pick;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_mux_y;

  state_t             w_nxt_state;
  logic [SEL_W-1:0]   w_nxt_ptr;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic [NUM_REQ-1:0] w_nxt_gnt;
  logic [SEL_W-1:0]   w_nxt_sel;
  logic               w_nxt_valid;
  logic               w_nxt_be;
  logic               w_grant;

  assign w_hold_req  = req[r_sel];
  assign w_at_max    = (r_cnt == HOLD_MAX);
  assign w_end       = (r_state == BUSY) && (!w_hold_req || w_at_max);
  assign w_ptr_after = r_sel + 1'b1;
  assign w_cnt_inc   = r_cnt + 1'b1;

  // Re-arbitration at the end of a burst already uses the advanced pointer,
  // so the outgoing requester lands at lowest priority in the same edge.
  assign w_arb_ptr = (r_state == BUSY) ? w_ptr_after : r_ptr;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (w_arb_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_gnt   = r_gnt;
    w_nxt_sel   = r_sel;
    w_nxt_valid = r_valid;
    w_nxt_be    = 1'b0;
    w_grant     = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_grant = w_found;
      end
      BUSY: begin
        if (w_end) begin
          w_nxt_ptr = w_ptr_after;
          w_grant   = w_found;
          // A burst that already hit its limit has pulsed burst_end; no second pulse.
          w_nxt_be  = !w_hold_req && !w_at_max;
          if (!w_found) begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = '0;
            w_nxt_valid = 1'b0;
            w_nxt_cnt   = '0;
          end
        end else begin
          w_nxt_cnt = w_cnt_inc;
          w_nxt_be  = (w_cnt_inc == HOLD_MAX);
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase

    if (w_grant) begin
      w_nxt_state = BUSY;
      w_nxt_gnt   = onehot16(w_pick);
      w_nxt_sel   = w_pick;
      w_nxt_valid = 1'b1;
      w_nxt_cnt   = CNT_W'(1);
      w_nxt_be    = w_nxt_be | ONE_SHOT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_sel       <= '0;
      r_valid     <= 1'b0;
      r_burst_end <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_ptr       <= w_nxt_ptr;
      r_cnt       <= w_nxt_cnt;
      r_gnt       <= w_nxt_gnt;
      r_sel       <= w_nxt_sel;
      r_valid     <= w_nxt_valid;
      r_burst_end <= w_nxt_be;
    end
  end

  mux_16cross1 u_mux (
    .d (data),
    .s (r_sel),
    .y (w_mux_y)
  );

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign valid     = r_valid;
  assign burst_end = r_burst_end;
  assign y         = w_mux_y & r_valid;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench: one arbiter with an 8-cycle burst limit and one with a
// 2-cycle limit, driven by shared stimulus.
module tb_mux16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] data;

  logic [15:0] gnt8, gnt2;
  logic [3:0]  sel8, sel2;
  logic        valid8, valid2, y8, y2, be8, be2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [15:0] req;
    logic [15:0] data;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    logic        y;
    logic        be;
  } vec_t;

  vec_t tab2[$];
  vec_t tab3[$];
  vec_t tab4[$];

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt8),
    .sel       (sel8),
    .valid     (valid8),
    .y         (y8),
    .burst_end (be8)
  );

  mux16_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt2),
    .sel       (sel2),
    .valid     (valid2),
    .y         (y2),
    .burst_end (be2)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input bit use2, input string tag, input logic [15:0] g,
                            input logic [3:0] s, input logic v, input logic yy, input logic b);
    if (use2) begin
      chk({tag, ".gnt"},   gnt2,          g);
      chk({tag, ".sel"},   16'(sel2),     16'(s));
      chk({tag, ".valid"}, 16'(valid2),   16'(v));
      chk({tag, ".y"},     16'(y2),       16'(yy));
      chk({tag, ".be"},    16'(be2),      16'(b));
    end else begin
      chk({tag, ".gnt"},   gnt8,          g);
      chk({tag, ".sel"},   16'(sel8),     16'(s));
      chk({tag, ".valid"}, 16'(valid8),   16'(v));
      chk({tag, ".y"},     16'(y8),       16'(yy));
      chk({tag, ".be"},    16'(be8),      16'(b));
    end
  endtask

  task automatic run_vec(input vec_t v, input bit use2, input string tag);
    req  = v.req;
    data = v.data;
    @(negedge clk);
    check_outs(use2, tag, v.gnt, v.sel, v.valid, v.y, v.be);
  endtask

  task automatic do_reset(input logic [15:0] r);
    rst_n = 1'b0;
    req   = r;
    data  = 16'($urandom);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  idx;
    logic [15:0] dlist [5];

    // Fairness with a 2-cycle limit: each requester holds for two cycles in turn.
    d = 16'hA5C3;
    for (int unsigned k = 0; k <= 32; k++) begin
      idx = 4'((k / 2) % 16);
      tab2.push_back('{16'hFFFF, d, 16'h0001 << idx, idx, 1'b1, d[idx], (k % 2) == 1});
    end

    // Early release of requester 4, handover to 8, then idle with sel kept.
    tab3.push_back('{16'h0110, 16'h0010, 16'h0010, 4'd4, 1'b1, 1'b1, 1'b0});
    tab3.push_back('{16'h0110, 16'h0000, 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0});
    tab3.push_back('{16'h0110, 16'h0110, 16'h0010, 4'd4, 1'b1, 1'b1, 1'b0});
    tab3.push_back('{16'h0100, 16'h0100, 16'h0100, 4'd8, 1'b1, 1'b1, 1'b1});
    tab3.push_back('{16'h0100, 16'h0010, 16'h0100, 4'd8, 1'b1, 1'b0, 1'b0});
    tab3.push_back('{16'h0000, 16'hFFFF, 16'h0000, 4'd8, 1'b0, 1'b0, 1'b1});
    tab3.push_back('{16'h0000, 16'h0100, 16'h0000, 4'd8, 1'b0, 1'b0, 1'b0});

    // Wrap-around: forced release of 15 goes to 1, then back to 15 at lowest priority.
    tab4.push_back('{16'h8000, 16'h8000, 16'h8000, 4'd15, 1'b1, 1'b1, 1'b0});
    for (int unsigned k = 2; k <= 8; k++)
      tab4.push_back('{16'h8002, 16'h8000, 16'h8000, 4'd15, 1'b1, 1'b1, k == 8});
    for (int unsigned k = 1; k <= 8; k++)
      tab4.push_back('{16'h8002, 16'h8000, 16'h0002, 4'd1, 1'b1, 1'b0, k == 8});
    tab4.push_back('{16'h8002, 16'h8000, 16'h8000, 4'd15, 1'b1, 1'b1, 1'b0});

    // Reset values, then first grant latency.
    rst_n = 1'b0;
    req   = 16'($urandom);
    data  = 16'($urandom);
    repeat (3) @(negedge clk);
    check_outs(1'b0, "rst_hold", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    req   = 16'h0000;
    rst_n = 1'b1;
    @(negedge clk);
    check_outs(1'b0, "rst_rel", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    run_vec('{16'h0001, 16'h0001, 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0}, 1'b0, "first_gnt");

    do_reset(16'hFFFF);
    for (int unsigned i = 0; i < tab2.size(); i++)
      run_vec(tab2[i], 1'b1, $sformatf("fair[%0d]", i));

    do_reset(16'h0000);
    for (int unsigned i = 0; i < tab3.size(); i++)
      run_vec(tab3[i], 1'b0, $sformatf("early[%0d]", i));

    do_reset(16'h0000);
    for (int unsigned i = 0; i < tab4.size(); i++)
      run_vec(tab4[i], 1'b0, $sformatf("wrap[%0d]", i));

    // Asynchronous reset in the middle of a burst.
    do_reset(16'h0000);
    run_vec('{16'h0040, 16'h0040, 16'h0040, 4'd6, 1'b1, 1'b1, 1'b0}, 1'b0, "mid_a");
    run_vec('{16'h0040, 16'h0040, 16'h0040, 4'd6, 1'b1, 1'b1, 1'b0}, 1'b0, "mid_b");
    #2 rst_n = 1'b0;
    #1 check_outs(1'b0, "mid_async", 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs(1'b0, "mid_regrant", 16'h0040, 4'd6, 1'b1, 1'b1, 1'b0);

    // Datapath: y follows bit 9 combinationally, other bits are ignored.
    do_reset(16'h0000);
    run_vec('{16'h0200, 16'h0000, 16'h0200, 4'd9, 1'b1, 1'b0, 1'b0}, 1'b0, "dp_gnt");
    dlist = '{16'h0200, 16'hFFFF, 16'hFDFF, 16'h0000, 16'h0200};
    for (int unsigned i = 0; i < 5; i++) begin
      data = dlist[i];
      #0.5;
      d = dlist[i];
      chk($sformatf("dp_tog[%0d].y", i), 16'(y8), 16'(d[9]));
    end
    @(negedge clk);
    for (int unsigned i = 0; i < 5; i++) begin
      d    = 16'($urandom);
      data = d;
      #1;
      chk($sformatf("dp_rand[%0d].y", i), 16'(y8), 16'(d[9]));
      chk($sformatf("dp_rand[%0d].sel", i), 16'(sel8), 16'd9);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares a 16:1 single-bit mux datapath among 16 requesters.
- Picks one requester, holds its grant for a bounded burst, and drives the 4-bit mux select.
- Presents the selected data bit with a valid flag to the single downstream consumer.
- Sits directly in front of the 16:1 mux (mux_16cross1) that it configures.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a single grant may last; legal range 1..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  16  request from requester i; held high while it wants the datapath
- data  input  16  data bit from requester i
- gnt  output  16  registered one-hot grant; all zeros when idle
- sel  output  4  registered mux select = index of granted requester
- valid  output  1  registered; high while any grant is active
- y  output  1  data[sel] when valid, else 0 (combinational from registered sel)
- burst_end  output  1  registered one-cycle pulse on the last cycle of each grant

Behaviour:
- Reset (async assert, sync release) values:
  - gnt=0, sel=0, valid=0, burst_end=0.
  - Hold counter = 0, state = IDLE, priority pointer ptr = 0.
- State IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, ..., ptr+15 (mod 16).
  - On the next edge: gnt = onehot(pick), sel = pick, valid = 1, counter = 1, go to BUSY.
  - Latency from req rising to gnt/valid high: 1 cycle.
- State BUSY, grant ends on an edge if any of the following holds:
  - req[sel] = 0 on that cycle: release, and this cycle is not counted as data.
  - counter == MAX_HOLD: forced release.
- Ending a grant:
  - ptr = sel + 1 (mod 16, so 15 wraps to 0).
  - If another request is pending, re-arbitrate in the same edge using the new ptr and grant again immediately (back-to-back, no idle cycle); counter = 1.
  - Otherwise gnt = 0, valid = 0, go to IDLE.
  - If req[sel] is still high after a forced release, that requester is eligible again, at lowest priority.
- Otherwise in BUSY: counter increments and the grant holds.
- burst_end is high on the cycle where counter == MAX_HOLD, or one cycle after req[sel] drops. It is visible together with the final valid cycle for forced releases.
- y is never X:
  - y = 0 whenever valid = 0.
  - sel keeps its last value while idle.
- Single requester, continuous req: re-granted to itself every MAX_HOLD cycles, with a burst_end pulse each time and no valid gap.
- MAX_HOLD = 1: every cycle re-arbitrates, giving pure per-cycle round robin.
- A requester that drops req while not granted loses nothing; there is no request queuing.
- rst_n asserted mid-burst: all outputs return to reset values immediately (asynchronous); ptr returns to 0.

Decomposition:
- Shared package mux_arb_pkg holds:
  - NUM_REQ = 16, SEL_W = 4
  - state enum {IDLE, BUSY}
- Sub-module rr_pick16, purely combinational:
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: found, idx[3:0].
  - Implementation: rotate, then priority-encode.
- The datapath instantiates the existing 16:1 mux, fed with data and sel. Its output is gated with valid.

Test Plan:
1. Reset: hold rst_n=0 with random req/data, then release -> gnt=0, valid=0, y=0, sel=0. Then req=16'h0001 -> next cycle gnt=16'h0001, sel=0, valid=1.
2. Fairness: req=16'hFFFF constant, MAX_HOLD=2 -> grants 0,0,1,1,2,2,...,15,15,0; burst_end every 2nd cycle; valid never drops.
3. Early release: req=16'h0110 with req[4] dropped after 3 cycles -> gnt=16'h0010 for 3 cycles, then 16'h0100 immediately; y tracks data[4] then data[8].
4. Wrap-around: grant on 15 ends, req=16'h8002 -> next grant goes to 1, not 15.
5. Mid-burst reset: req=16'h0040 granted; rst_n pulsed low mid-cycle -> gnt, valid and y go to 0 asynchronously; after release, re-grant to 6 one cycle later.
6. Data path: granted sel=9 with data toggling on bit 9 only -> y follows bit 9 the same cycle; toggles on other bits do not change y.
